// File: rtl/btn_bank.sv
// ---------------------------------------------------------------------------
// btn_bank -- N-channel push-button conditioner for the alarm-clock panel.
//
// Each channel synchronises a raw button level (two flops), debounces it
// with a cycle counter, and produces registered one-cycle press / release /
// long-press (hold) pulses. Channels are fully independent.
//
// Optional feature: define BTN_AUTOREPEAT_EN to make a held button emit a
// press pulse every REPEAT_CYCLES cycles after the hold pulse.
//
// Ports (btn_bank):
//   i_clk      system clock, all state changes on the rising edge
//   i_rst      synchronous active-high reset
//   i_in[N]    raw asynchronous button levels, active-high
//   o_level[N] debounced accepted level
//   o_press[N] one-cycle pulse on accepted rise (plus auto-repeat pulses)
//   o_release[N] one-cycle pulse on accepted fall
//   o_hold[N]  one-cycle pulse after HOLD_CYCLES cycles of level high
// ---------------------------------------------------------------------------

module btn_chan #(
    parameter int DEB_CYCLES    = 16,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);
    localparam int HMAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int DW       = $clog2(DEB_CYCLES + 1);
    localparam int HW       = $clog2(HMAX_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} state_t;

    logic          r_s1, r_s2, r_level;
    logic          r_press, r_release, r_hold;
    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hcnt;
    state_t        r_state;

    logic w_accept, w_rise, w_fall;

    // The DEB_CYCLES-th consecutive disagreeing sample flips the level now.
    assign w_accept = (r_s2 != r_level) && (r_dcnt == DEB_LAST);
    assign w_rise   = w_accept &&  r_s2;
    assign w_fall   = w_accept && !r_s2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;
            r_state   <= ST_IDLE;
        end else begin
            r_s1      <= i_in;
            r_s2      <= r_s1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;

            // Debounce: any agreeing sample restarts the count.
            if (r_s2 == r_level) begin
                r_dcnt <= '0;
            end else if (w_accept) begin
                r_level <= r_s2;
                r_dcnt  <= '0;
            end else begin
                r_dcnt <= r_dcnt + DW'(1);
            end

            // Pulses are registered alongside the level so they line up with
            // the first cycle the new level is visible. The fall check comes
            // first so a release suppresses any hold/repeat in that cycle.
            if (w_fall) begin
                r_state   <= ST_IDLE;
                r_hcnt    <= '0;
                r_release <= 1'b1;
            end else if (w_rise) begin
                r_state <= ST_PRESSED;
                r_hcnt  <= '0;
                r_press <= 1'b1;
            end else begin
                case (r_state)
                    ST_PRESSED: begin
                        if (r_level) begin
                            if (r_hcnt == HOLD_LAST) begin
                                r_state <= ST_HELD;
                                r_hold  <= 1'b1;
                                r_hcnt  <= '0;
                            end else if (r_hcnt != '1) begin
                                r_hcnt <= r_hcnt + HW'(1);
                            end
                        end
                    end
                    ST_HELD: begin
`ifdef BTN_AUTOREPEAT_EN
                        if (r_level) begin
                            if (r_hcnt == REP_LAST) begin
                                r_press <= 1'b1;
                                r_hcnt  <= '0;
                            end else if (r_hcnt != '1) begin
                                r_hcnt <= r_hcnt + HW'(1);
                            end
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_hold    = r_hold;
endmodule

module btn_bank #(
    parameter int N             = 5,
    parameter int DEB_CYCLES    = 16,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_in,
    output logic [N-1:0] o_level,
    output logic [N-1:0] o_press,
    output logic [N-1:0] o_release,
    output logic [N-1:0] o_hold
);
    for (genvar g = 0; g < N; g++) begin : g_chan
        btn_chan #(
            .DEB_CYCLES   (DEB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_in     (i_in[g]),
            .o_level  (o_level[g]),
            .o_press  (o_press[g]),
            .o_release(o_release[g]),
            .o_hold   (o_hold[g])
        );
    end
endmodule

// File: tb/tb_btn_bank.sv
// ---------------------------------------------------------------------------
// tb_btn_bank -- self-checking bench for btn_bank (N=5, DEB=4, HOLD=10,
// REPEAT=3). A behavioural model (input delay line, disagreement run length,
// time-since-press age) predicts every output each cycle; directed scenarios
// add hand-computed timing and count expectations.
// ---------------------------------------------------------------------------
module tb_btn_bank;
    localparam int N    = 5;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] in_v = '0;
    logic [N-1:0] level, press, rel, hold;

    always #5 clk = ~clk;

    btn_bank #(
        .N(N), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_in(in_v),
        .o_level(level), .o_press(press), .o_release(rel), .o_hold(hold)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    bit           m_d1[N], m_d2[N], m_lvl[N], m_s2;
    int           m_run[N], m_age[N];
    bit           m_on = 1'b0;
    logic [N-1:0] e_level = '0, e_press = '0, e_rel = '0, e_hold = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1;
            for (int c = 0; c < N; c++) begin
                m_d1[c] = 0; m_d2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_age[c] = 0;
            end
            e_level = '0; e_press = '0; e_rel = '0; e_hold = '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                m_s2 = m_d2[c];
                m_d2[c] = m_d1[c];
                m_d1[c] = in_v[c];
                e_press[c] = 0; e_rel[c] = 0; e_hold[c] = 0;
                if (m_s2 != m_lvl[c]) m_run[c]++; else m_run[c] = 0;
                if (m_run[c] == DEB) begin
                    m_lvl[c] = m_s2;
                    m_run[c] = 0;
                    if (m_s2) begin
                        e_press[c] = 1;
                        m_age[c]   = 0;
                    end else begin
                        e_rel[c] = 1;
                    end
                end else if (m_lvl[c]) begin
                    m_age[c]++;
                    if (m_age[c] == HOLD) e_hold[c] = 1;
`ifdef BTN_AUTOREPEAT_EN
                    else if (m_age[c] > HOLD && (m_age[c] - HOLD) % REP == 0) e_press[c] = 1;
`endif
                end
                e_level[c] = m_lvl[c];
            end
        end
    end

    // ---------------- per-cycle compare + event recorder ----------------
    int np[N], nr[N], nh[N], nl[N], tp1[N], tp2[N], tp3[N], th[N], tr[N];

    always @(negedge clk) begin
        if (m_on) begin
            chk("level",   32'(level), 32'(e_level));
            chk("press",   32'(press), 32'(e_press));
            chk("release", 32'(rel),   32'(e_rel));
            chk("hold",    32'(hold),  32'(e_hold));
        end
        for (int c = 0; c < N; c++) begin
            if (press[c] === 1'b1) begin
                if (np[c] == 0) tp1[c] = cyc;
                else if (np[c] == 1) tp2[c] = cyc;
                else if (np[c] == 2) tp3[c] = cyc;
                np[c]++;
            end
            if (rel[c] === 1'b1) begin
                if (nr[c] == 0) tr[c] = cyc;
                nr[c]++;
            end
            if (hold[c] === 1'b1) begin
                if (nh[c] == 0) th[c] = cyc;
                nh[c]++;
            end
            if (level[c] === 1'b1) nl[c]++;
        end
    end

    task automatic clr();
        for (int c = 0; c < N; c++) begin
            np[c] = 0; nr[c] = 0; nh[c] = 0; nl[c] = 0;
            tp1[c] = 0; tp2[c] = 0; tp3[c] = 0; th[c] = 0; tr[c] = 0;
        end
    endtask

    // Inputs change 1 time unit after the falling edge, after the recorder.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    int k, kf;
    logic [14:0] bpat;

    initial begin
        clr();
        rst  = 1'b1;
        in_v = '0;
        step(3);
        chk("rst_level", 32'(level), 0);
        chk("rst_pulses", 32'(press | rel | hold), 0);
        rst = 1'b0;
        step(2);

        // Clean press on channel 0, held 20 cycles
        clr();
        in_v[0] = 1'b1; k = cyc + 1;
        step(20);
        in_v[0] = 1'b0; kf = cyc + 1;
        step(12);
        chk("t1_press_lat", tp1[0] - k, DEB + 1);
        chk("t1_hold_gap", th[0] - tp1[0], HOLD);
        chk("t1_hold_cnt", nh[0], 1);
        chk("t1_rel_lat", tr[0] - kf, DEB + 1);
`ifdef BTN_AUTOREPEAT_EN
        chk("t1_press_cnt", np[0], 4);
`else
        chk("t1_press_cnt", np[0], 1);
`endif
        chk("t1_quiet", np[1] + np[2] + np[3] + np[4] + nl[1] + nl[2] + nl[3] + nl[4], 0);

        // Bounce on channel 2: high phases of 1..3 cycles, then stable
        clr();
        bpat = 15'b011010011101101;  // bit 0 applied first
        for (int i = 0; i < 15; i++) begin
            in_v[2] = bpat[i];
            step(1);
        end
        in_v[2] = 1'b1; k = cyc + 1;
        step(20);
        in_v[2] = 1'b0; kf = cyc + 1;
        step(12);
        chk("t2_first_press", tp1[2] - k, DEB + 1);
        chk("t2_rel_cnt", nr[2], 1);
        chk("t2_rel_lat", tr[2] - kf, DEB + 1);
`ifdef BTN_AUTOREPEAT_EN
        chk("t2_press_cnt", np[2], 4);
`else
        chk("t2_press_cnt", np[2], 1);
`endif

        // Short glitch on channel 1
        clr();
        in_v[1] = 1'b1;
        step(3);
        in_v[1] = 1'b0;
        step(10);
        chk("t3_glitch", nl[1] + np[1] + nr[1] + nh[1], 0);

        // Channels 0 and 4 rise together; 4 released before hold
        clr();
        in_v[0] = 1'b1; in_v[4] = 1'b1; k = cyc + 1;
        step(8);
        in_v[4] = 1'b0;
        step(7);
        in_v[0] = 1'b0;
        step(12);
        chk("t4_same_press", tp1[4] - tp1[0], 0);
        chk("t4_press_lat", tp1[4] - k, DEB + 1);
        chk("t4_rel4", nr[4], 1);
        chk("t4_no_hold4", nh[4], 0);
        chk("t4_hold0", nh[0], 1);
        chk("t4_hold0_gap", th[0] - tp1[0], HOLD);

        // Reset five cycles after a press on channel 3
        clr();
        in_v[3] = 1'b1;
        for (int i = 0; i < 20 && np[3] == 0; i++) step(1);
        chk("t5_press_seen", (np[3] > 0) ? 1 : 0, 1);
        step(4);
        rst = 1'b1;
        step(1);
        chk("t5_rst_clear", 32'(level | press | rel | hold), 0);
        chk("t5_no_rel", nr[3], 0);
        rst = 1'b0;
        clr();
        k = cyc + 1;
        step(25);
        chk("t5_repress_lat", tp1[3] - k, DEB + 1);
        chk("t5_rehold_gap", th[3] - tp1[3], HOLD);
        chk("t5_no_rel2", nr[3], 0);
        in_v[3] = 1'b0;
        step(12);
        chk("t5_final_rel", nr[3], 1);

        // Long hold on channel 0 (auto-repeat when enabled)
        clr();
        in_v[0] = 1'b1;
        step(40);
        in_v[0] = 1'b0;
        step(12);
        chk("t6_hold_gap", th[0] - tp1[0], HOLD);
`ifdef BTN_AUTOREPEAT_EN
        chk("t6_rep1", tp2[0] - tp1[0], HOLD + REP);
        chk("t6_rep2", tp3[0] - tp2[0], REP);
        chk("t6_press_cnt", np[0], 10);
`else
        chk("t6_press_cnt", np[0], 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
